line_fill_responder: RTL and testbench
======================================

Name: line_fill_responder

Overview:
- Backing-memory responder at the far end of the data-cache miss interface.
- Accepts one line request at a time: a refill read or an eviction write.
- Applies a fixed access latency, then streams the line back critical-word-first, or acknowledges the write.
- Sits below the data cache and serves as the main-memory model for core simulation.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, beat width; equals core register width.
- LINE_WORDS, 4, words per cache line; power of two, at least 2.
- MEM_WORDS, 4096, storage depth in words; power of two.
- LATENCY, 4, idle cycles between request acceptance (or last write beat) and the first response; at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = line write (eviction), 0 = line read (refill).
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- wdata_valid  in  1  write beat present.
- wdata_ready  out  1  write beat accepted.
- wdata  in  DATA_WIDTH  write beat data.
- resp_valid  out  1  response beat present.
- resp_ready  in  1  cache accepts the response beat.
- resp_data  out  DATA_WIDTH  read beat data; 0 on a write ack.
- resp_last  out  1  final beat of the read burst, or the write ack.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset:
  - State goes to IDLE; counters clear.
  - req_ready=1, wdata_ready=0, resp_valid=0, resp_data=0, resp_last=0, busy=0.
  - Storage array is not reset.
  - Reset mid-transaction abandons the transaction; no partial line is committed beyond beats already written.
- Handshakes: a transfer occurs on any edge where valid and ready are both high. Once asserted, resp_valid, resp_data and resp_last hold stable until accepted.
- Address:
  - word_idx = req_addr[2 +: log2(MEM_WORDS)]; upper bits are discarded, so addresses wrap modulo MEM_WORDS.
  - Line base = word_idx with the low log2(LINE_WORDS) bits cleared.
  - Beat offset starts at the requested word offset and increments modulo LINE_WORDS, so the burst wraps inside the line.
- IDLE: req_ready=1. On acceptance, latch the address and direction. A write goes to WDATA; a read goes to WAIT with the latency counter loaded to LATENCY.
- WDATA:
  - wdata_ready=1, req_ready=0.
  - Each accepted beat writes mem[base + offset] in the same edge, then offset advances.
  - After LINE_WORDS beats, go to WAIT.
  - Writes always start at offset 0, the line-aligned order; the req_addr low offset bits are ignored for writes.
- WAIT: counter decrements each cycle. When it reaches 1, go to RBURST (read) or WACK (write). The first response is therefore visible exactly LATENCY cycles after the accepting edge (read) or after the last-beat edge (write).
- RBURST:
  - resp_valid=1, resp_data = mem[base + offset].
  - resp_last=1 on the LINE_WORDS-th beat.
  - Offset advances only on acceptance.
  - After the last beat is accepted, go to IDLE.
- WACK: resp_valid=1, resp_last=1, resp_data=0. On acceptance, go to IDLE.
- req_ready is 0 in every state except IDLE. A request held during busy waits; it is not dropped.
- Back-to-back: req_ready rises the cycle after final acceptance. There is no combinational path from resp_ready to req_ready.
- Read-after-write to the same line returns the newly written data, because writes commit before WAIT.
- busy is 1 in every state except IDLE.

Test Plan:
- Reset: hold rst 2 cycles -> req_ready=1, resp_valid=0, busy=0, wdata_ready=0.
- Write then read, LATENCY=4:
  - Write line at 0x100 with beats 0xA0..0xA3 -> ack appears 4 cycles after the last beat, resp_last=1, resp_data=0.
  - Read 0x100 -> first beat 4 cycles after acceptance; data 0xA0,0xA1,0xA2,0xA3; resp_last only on the 4th beat.
- Critical-word-first: read req_addr=0x108 after the write above -> beats 0xA2,0xA3,0xA0,0xA1.
- Backpressure: drop resp_ready for 3 cycles on beat 2 -> resp_data holds 0xA1 stable, no beat is skipped or repeated, 4 total beats.
- Address wrap: MEM_WORDS=4096; write line at 0x4000_0100, read 0x100 -> returns the same data.
- Reset mid-burst: assert rst after beat 1 of a read -> next cycle resp_valid=0, req_ready=1; a new read of the same line returns the full 4 beats correctly.

Source files
------------

// File: rtl/line_fill_responder.sv
// Backing-memory responder for the data-cache miss interface: serves one line
// refill (critical-word-first) or one line eviction at a time after a fixed latency.
module line_fill_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int MEM_WORDS  = 4096,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_last,
  output logic                  busy
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = IDX_W - OFF_W;
  localparam int CNT_W  = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WAIT,
    S_RBURST,
    S_WACK
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [LINE_W-1:0] line_q;
  logic [OFF_W-1:0]  off_q;
  logic [OFF_W-1:0]  beat_q;
  logic              is_write_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [IDX_W-1:0]  mem_addr;
  logic              last_beat;
  logic              unused_addr_bits;

  assign mem_addr  = {line_q, off_q};
  assign last_beat = (beat_q == OFF_W'(LINE_WORDS - 1));

  // Byte-lane bits and address bits above the storage depth are discarded.
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[ADDR_WIDTH-1:2+IDX_W]};

  always_comb begin
    // NOTE: every output and next-state gets a default first so no path infers a latch.
    state_nxt   = state;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    resp_valid  = 1'b0;
    resp_last   = 1'b0;
    resp_data   = '0;
    busy        = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = req_write ? S_WDATA : S_WAIT;
      end
      S_WDATA: begin
        wdata_ready = 1'b1;
        if (wdata_valid && last_beat) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) state_nxt = is_write_q ? S_WACK : S_RBURST;
      end
      S_RBURST: begin
        resp_valid = 1'b1;
        resp_data  = mem[mem_addr];
        resp_last  = last_beat;
        if (resp_ready && last_beat) state_nxt = S_IDLE;
      end
      S_WACK: begin
        resp_valid = 1'b1;
        resp_last  = 1'b1;
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state      <= S_IDLE;
      line_q     <= '0;
      off_q      <= '0;
      beat_q     <= '0;
      is_write_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            line_q     <= req_addr[2+OFF_W +: LINE_W];
            // Evictions are always delivered line-aligned, reads start at the critical word.
            off_q      <= req_write ? '0 : req_addr[2 +: OFF_W];
            beat_q     <= '0;
            is_write_q <= req_write;
            cnt_q      <= CNT_W'(LATENCY);
          end
        end
        S_WDATA: begin
          if (wdata_valid) begin
            off_q  <= off_q + 1'b1;
            beat_q <= beat_q + 1'b1;
          end
        end
        S_WAIT: cnt_q <= cnt_q - 1'b1;
        S_RBURST: begin
          if (resp_ready) begin
            off_q  <= off_q + 1'b1;
            beat_q <= beat_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; it models DRAM contents and would otherwise
  // cost a clear of every word. Writes are blocked during reset so an abandoned
  // eviction commits nothing further.
  always_ff @(posedge clk) begin
    if (!rst && state == S_WDATA && wdata_valid) mem[mem_addr] <= wdata;
  end

endmodule

// File: tb/tb_line_fill_responder.sv
// Scoreboard bench for line_fill_responder: expected beats are queued at request time
// and compared by a monitor as the responder hands them over.
module tb_line_fill_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_last;
  logic        busy;

  line_fill_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4), .MEM_WORDS(4096), .LATENCY(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [32:0] sb_q[$];           // {last, data}
  logic [31:0] model [0:4095];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare every accepted beat; also require a stalled beat to stay put.
  logic        prev_stall = 1'b0;
  logic [32:0] prev_beat = '0;
  logic [32:0] exp_beat;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_beat", {resp_valid, resp_last, resp_data}, {1'b1, prev_beat});
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_beat", {resp_last, resp_data}, 33'h0);
        end else begin
          exp_beat = sb_q.pop_front();
          check("resp_data", resp_data, exp_beat[31:0]);
          check("resp_last", resp_last, exp_beat[32]);
        end
      end
      prev_stall = resp_valid && !resp_ready;
      prev_beat  = {resp_last, resp_data};
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_first_resp(input string tag);
    int lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check(tag, lat, 4);
  endtask

  task automatic issue_req(input logic wr, input logic [31:0] addr);
    wait_idle();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("busy_after_accept", {busy, req_ready}, 2'b10);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] beats [4];
    logic [11:0] base;
    beats[0] = d0; beats[1] = d1; beats[2] = d2; beats[3] = d3;
    base = {addr[13:4], 2'b00};
    issue_req(1'b1, addr);
    for (int i = 0; i < 4; i++) begin
      wdata_valid = 1'b1;
      wdata       = beats[i];
      check("wdata_ready", wdata_ready, 1);
      @(posedge clk); #1;
      model[base + 12'(i)] = beats[i];
    end
    wdata_valid = 1'b0;
    sb_q.push_back({1'b1, 32'h0});
    wait_first_resp("write_ack_latency");
    wait_idle();
  endtask

  task automatic push_read(input logic [31:0] addr, input int nbeats);
    logic [11:0] base;
    logic [1:0]  off;
    base = {addr[13:4], 2'b00};
    off  = addr[3:2];
    for (int i = 0; i < nbeats; i++) begin
      sb_q.push_back({(i == 3), model[base + {10'd0, off + 2'(i)}]});
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input bit stall);
    push_read(addr, 4);
    issue_req(1'b0, addr);
    wait_first_resp("read_latency");
    if (stall) begin
      @(posedge clk); #1;          // beat 1 accepted here
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      resp_ready = 1'b1;
    end
    wait_idle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_wdata_ready", wdata_ready, 0);
    check("rst_resp_last", resp_last, 0);
    check("rst_resp_data", resp_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write then aligned read, critical-word-first and backpressured reads.
    do_write(32'h0000_0100, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    do_read(32'h0000_0100, 1'b0);
    do_read(32'h0000_0108, 1'b0);
    do_read(32'h0000_0100, 1'b1);

    // Last line of storage, read starting at the final word so the burst wraps.
    do_write(32'h0000_3FF0, $urandom, $urandom, $urandom, $urandom);
    do_read(32'h0000_3FFC, 1'b0);

    // Address wrap: upper bits discarded; a non-zero write offset is ignored.
    do_write(32'h4000_0104, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
    do_read(32'h0000_0100, 1'b0);
    check("wrap_model", model[12'h040], 32'hB0);

    // Reset after the first beat of a read abandons the burst.
    push_read(32'h0000_0100, 1);
    issue_req(1'b0, 32'h0000_0100);
    wait_first_resp("read_latency_pre_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_read(32'h0000_0100, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
